// File: rtl/rv32_mem_pkg.sv
// ---------------------------------------------------------------------------
// rv32_mem_pkg
//   Shared definitions for the RV32 data-memory slice: Func3 access-size
//   codes, the wait-state FSM encoding and the store byte-lane decoder.
// ---------------------------------------------------------------------------
package rv32_mem_pkg;

  // Func3 encodings for loads and stores (size in the low bits, bit 2 = unsigned)
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Wait-state controller states, used only when extra latency is configured
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mem_state_t;

  // Byte-lane enables for a store; lane k is the byte at (address + k).
  // Only SB/SH/SW write anything; every other code leaves memory untouched.
  function automatic logic [3:0] store_lane_mask(input logic [2:0] func3);
    logic [3:0] mask;
    case (func3)
      F3_B:    mask = 4'b0001;
      F3_H:    mask = 4'b0011;
      F3_W:    mask = 4'b1111;
      default: mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/data_memory_load_extend.sv
// ---------------------------------------------------------------------------
// load_extend
//   Combinational load formatter. Takes the four bytes fetched starting at
//   the access address (byte 0 in bits [7:0]) and returns the sized,
//   sign- or zero-extended 32-bit load result.
// Ports
//   enable    in   1   1 = a load is completing this cycle; 0 forces zero
//   bytes_in  in  32   fetched bytes, little-endian (byte k in [8k+7:8k])
//   func3     in   3   access size/sign (B, H, W, BU, HU)
//   data_out  out 32   extended load data; 0 for unsupported codes
// ---------------------------------------------------------------------------
module load_extend
  import rv32_mem_pkg::*;
(
  input  logic        enable,
  input  logic [31:0] bytes_in,
  input  logic [2:0]  func3,
  output logic [31:0] data_out
);

  logic [31:0] sized_s;

  // Select the accessed bytes and extend according to the access type
  always_comb begin
    sized_s = 32'h0000_0000;
    case (func3)
      F3_B:    sized_s = {{24{bytes_in[7]}}, bytes_in[7:0]};
      F3_H:    sized_s = {{16{bytes_in[15]}}, bytes_in[15:0]};
      F3_W:    sized_s = bytes_in;
      F3_BU:   sized_s = {24'h00_0000, bytes_in[7:0]};
      F3_HU:   sized_s = {16'h0000, bytes_in[15:0]};
      default: sized_s = 32'h0000_0000;
    endcase
  end

  // Hold the result at zero whenever no load is completing
  always_comb begin
    data_out = 32'h0000_0000;
    if (enable) begin
      data_out = sized_s;
    end else begin
      data_out = 32'h0000_0000;
    end
  end

endmodule

// File: rtl/data_memory.sv
// ---------------------------------------------------------------------------
// data_memory
//   Byte-addressable little-endian data memory for the RV32IM MEM stage.
//   Loads are combinational from the byte array; stores commit on the rising
//   clock edge. With LATENCY > 0 a small IDLE/WAIT controller raises
//   busywait so the pipeline stalls for LATENCY extra edges per access.
// Parameters
//   DEPTH_BYTES  storage size in bytes (power of two); index = Address mod size
//   LATENCY      extra wait edges per access; 0 = single cycle, busywait = 0
// Ports
//   Clock       in   1   rising-edge clock
//   Reset       in   1   asynchronous active-low reset; clears all storage
//   Read        in   1   load request
//   Write       in   1   store request (wins over Read when both are set)
//   Address     in  32   byte address, any alignment, wraps at top of memory
//   Write_data  in  32   store data, low byte/half/word used per Func3
//   Func3       in   3   access size/sign
//   Read_data   out 32   extended load result, 0 when no load completes
//   busywait    out  1   1 = access in progress, requester holds its inputs
// ---------------------------------------------------------------------------
module data_memory
  import rv32_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BYTES = 1024,
  parameter int unsigned LATENCY     = 0
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] Address,
  input  logic [31:0] Write_data,
  input  logic [2:0]  Func3,
  output logic [31:0] Read_data,
  output logic        busywait
);

  localparam int unsigned AW = $clog2(DEPTH_BYTES);

  logic [7:0]    mem_r [DEPTH_BYTES];
  logic [AW-1:0] base_idx_s;
  logic [AW-1:0] lane_idx_s [4];
  logic [31:0]   fetch_s;
  logic [3:0]    lane_we_s;
  logic          req_s;
  logic          done_s;
  logic          busy_s;
  logic          store_s;
  logic          load_s;
  logic          unused_addr_s;

  // Address bits above the array size simply alias onto the same bytes
  assign base_idx_s    = Address[AW-1:0];
  assign unused_addr_s = ^Address[31:AW];

  assign req_s = Read | Write;

  // A store has priority over a load when both are requested
  assign store_s = Write & done_s;
  assign load_s  = Read & ~Write & done_s & Reset;

  // Per-lane byte indices; the AW-bit add wraps misaligned accesses to index 0
  always_comb begin
    fetch_s = 32'h0000_0000;
    for (int k = 0; k < 4; k++) begin
      lane_idx_s[k]      = base_idx_s + AW'(k);
      fetch_s[8*k +: 8]  = mem_r[lane_idx_s[k]];
    end
  end

  // Store byte-lane enables, active only when a store completes this cycle
  always_comb begin
    lane_we_s = 4'b0000;
    if (store_s) begin
      lane_we_s = store_lane_mask(Func3);
    end else begin
      lane_we_s = 4'b0000;
    end
  end

  // Byte storage: cleared by reset, written lane by lane on store completion
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < int'(DEPTH_BYTES); i++) begin
        mem_r[i] <= 8'h00;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (lane_we_s[k]) begin
          mem_r[lane_idx_s[k]] <= Write_data[8*k +: 8];
        end
      end
    end
  end

  generate
    if (LATENCY == 0) begin : g_single_cycle
      // Every access completes in the cycle it is presented
      assign busy_s = 1'b0;
      assign done_s = 1'b1;
    end else begin : g_wait_states
      localparam int unsigned   CW       = $clog2(LATENCY + 1);
      localparam logic [CW-1:0] CNT_LAST = CW'(LATENCY);
      localparam logic [CW-1:0] CNT_ONE  = CW'(1);

      mem_state_t    state_r;
      mem_state_t    state_nx_s;
      logic [CW-1:0] cnt_r;
      logic [CW-1:0] cnt_nx_s;

      // Wait-state register; reset abandons any access in flight
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
          state_r <= ST_IDLE;
          cnt_r   <= '0;
        end else begin
          state_r <= state_nx_s;
          cnt_r   <= cnt_nx_s;
        end
      end

      // Next state, wait counter and busy/done decode. The counter is
      // loaded with 1 on the IDLE->WAIT edge so it reaches LATENCY after
      // exactly LATENCY edges with busywait high; the access then completes
      // on the following edge with busywait low.
      always_comb begin
        state_nx_s = state_r;
        cnt_nx_s   = cnt_r;
        busy_s     = 1'b0;
        done_s     = 1'b0;
        case (state_r)
          ST_IDLE: begin
            if (req_s) begin
              state_nx_s = ST_WAIT;
              cnt_nx_s   = CNT_ONE;
              busy_s     = 1'b1;
            end else begin
              state_nx_s = ST_IDLE;
              cnt_nx_s   = '0;
            end
          end
          ST_WAIT: begin
            if (!req_s) begin
              // Requester withdrew: abort without touching memory
              state_nx_s = ST_IDLE;
              cnt_nx_s   = '0;
            end else if (cnt_r == CNT_LAST) begin
              state_nx_s = ST_IDLE;
              cnt_nx_s   = '0;
              done_s     = 1'b1;
            end else begin
              cnt_nx_s = cnt_r + CNT_ONE;
              busy_s   = 1'b1;
            end
          end
          default: begin
            state_nx_s = ST_IDLE;
            cnt_nx_s   = '0;
          end
        endcase
      end
    end
  endgenerate

  assign busywait = busy_s & Reset;

  load_extend u_load_extend (
    .enable   (load_s),
    .bytes_in (fetch_s),
    .func3    (Func3),
    .data_out (Read_data)
  );

endmodule

// File: tb/tb_data_memory.sv
module tb_data_memory;
  import rv32_mem_pkg::*;

  localparam int unsigned DEPTH = 1024;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic        Reset;
  logic        m_read, m_write;
  logic [31:0] m_addr, m_wdata, m_rdata;
  logic [2:0]  m_f3;
  logic        m_busy;
  logic        l_read, l_write;
  logic [31:0] l_addr, l_wdata, l_rdata;
  logic [2:0]  l_f3;
  logic        l_busy;

  data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(0)) dut (
    .Clock(Clock), .Reset(Reset), .Read(m_read), .Write(m_write),
    .Address(m_addr), .Write_data(m_wdata), .Func3(m_f3),
    .Read_data(m_rdata), .busywait(m_busy)
  );

  data_memory #(.DEPTH_BYTES(DEPTH), .LATENCY(2)) dut_l2 (
    .Clock(Clock), .Reset(Reset), .Read(l_read), .Write(l_write),
    .Address(l_addr), .Write_data(l_wdata), .Func3(l_f3),
    .Read_data(l_rdata), .busywait(l_busy)
  );

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    int          tag;
    bit          l2;
    bit          chk_data;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  vec_t vt[$];
  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int tag,
                       input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s #%0d: got 0x%08h, expected 0x%08h", name, tag, act, req);
  endtask

  task automatic expect_out(input int tag, input bit l2, input bit chk_data,
                            input logic [31:0] data, input logic busy);
    exp_t e;
    e.tag = tag; e.l2 = l2; e.chk_data = chk_data; e.data = data; e.busy = busy;
    exp_q.push_back(e);
  endtask

  task automatic score_one();
    exp_t e;
    e = exp_q.pop_front();
    if (e.l2) begin
      if (e.chk_data) check("l2_read_data", e.tag, l_rdata, e.data);
      check("l2_busywait", e.tag, {31'b0, l_busy}, {31'b0, e.busy});
    end else begin
      if (e.chk_data) check("read_data", e.tag, m_rdata, e.data);
      check("busywait", e.tag, {31'b0, m_busy}, {31'b0, e.busy});
    end
  endtask

  // Sample at the falling edge, then let the rising edge commit, drive #1 later
  task automatic step();
    @(negedge Clock);
    while (exp_q.size() > 0) score_one();
    @(posedge Clock);
    #1;
  endtask

  task automatic add_vec(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] w, input logic [2:0] f,
                         input logic [31:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wdata = w; v.f3 = f; v.exp_data = e;
    vt.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int tag);
    m_read  = v.rd;
    m_write = v.wr;
    m_addr  = v.addr;
    m_wdata = v.wdata;
    m_f3    = v.f3;
    expect_out(tag, 1'b0, 1'b1, v.exp_data, 1'b0);
    step();
  endtask

  task automatic main_idle();
    m_read = 1'b0; m_write = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_f3 = F3_W;
  endtask

  task automatic l2_drive(input logic rd, input logic wr, input logic [31:0] a,
                          input logic [31:0] w);
    l_read = rd; l_write = wr; l_addr = a; l_wdata = w; l_f3 = F3_W;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach its summary");
    $fatal(1);
  end

  initial begin
    vec_t v;
    // rd wr addr wdata f3 expected Read_data
    add_vec(1'b1, 1'b0, 32'h0000_0000, 32'h0,          F3_W,   32'h0000_0000);
    add_vec(1'b0, 1'b1, 32'h0000_0004, 32'h1234_5678,  F3_W,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0004, 32'h0,          F3_W,   32'h1234_5678);
    add_vec(1'b1, 1'b0, 32'h0000_0004, 32'h0,          F3_BU,  32'h0000_0078);
    add_vec(1'b1, 1'b0, 32'h0000_0006, 32'h0,          F3_HU,  32'h0000_1234);
    add_vec(1'b0, 1'b1, 32'h0000_0005, 32'h0000_00AA,  F3_B,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0005, 32'h0,          F3_B,   32'hFFFF_FFAA);
    add_vec(1'b1, 1'b0, 32'h0000_0005, 32'h0,          F3_BU,  32'h0000_00AA);
    add_vec(1'b1, 1'b0, 32'h0000_0004, 32'h0,          F3_W,   32'h1234_AA78);
    add_vec(1'b0, 1'b1, 32'h0000_0006, 32'h0000_BBBB,  F3_H,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0006, 32'h0,          F3_H,   32'hFFFF_BBBB);
    add_vec(1'b1, 1'b0, 32'h0000_0004, 32'h0,          F3_W,   32'hBBBB_AA78);
    add_vec(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF,  F3_W,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          F3_W,   32'hDEAD_BEEF);
    add_vec(1'b1, 1'b1, 32'h0000_0020, 32'h1111_1111,  F3_W,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0020, 32'h0,          F3_W,   32'h1111_1111);
    add_vec(1'b0, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF,  3'b011, 32'h0000_0000);
    add_vec(1'b0, 1'b1, 32'h0000_0020, 32'h0000_0000,  F3_BU,  32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0020, 32'h0,          F3_W,   32'h1111_1111);
    add_vec(1'b0, 1'b1, 32'h0000_0020, 32'h9999_7777,  F3_H,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0020, 32'h0,          F3_W,   32'h1111_7777);
    add_vec(1'b1, 1'b0, 32'h0000_0021, 32'h0,          F3_W,   32'h0011_1177);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          3'b011, 32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          3'b110, 32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          3'b111, 32'h0000_0000);
    add_vec(1'b0, 1'b0, 32'h0000_0010, 32'h0,          F3_W,   32'h0000_0000);
    add_vec(1'b0, 1'b1, DEPTH - 2,     32'hA1B2_C3D4,  F3_W,   32'h0000_0000);
    add_vec(1'b1, 1'b0, DEPTH - 2,     32'h0,          F3_W,   32'hA1B2_C3D4);
    add_vec(1'b1, 1'b0, 32'h0000_0000, 32'h0,          F3_HU,  32'h0000_A1B2);
    add_vec(1'b1, 1'b0, 32'h0000_0000, 32'h0,          F3_W,   32'h0000_A1B2);
    add_vec(1'b1, 1'b0, 32'h0000_0400, 32'h0,          F3_W,   32'h0000_A1B2);
    add_vec(1'b1, 1'b0, DEPTH - 1,     32'h0,          F3_H,   32'hFFFF_B2C3);
    add_vec(1'b0, 1'b1, 32'h0000_0011, 32'hFFFF_FF55,  F3_B,   32'h0000_0000);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          F3_W,   32'hDEAD_55EF);
    add_vec(1'b1, 1'b0, 32'h0000_0012, 32'h0,          F3_HU,  32'h0000_DEAD);
    add_vec(1'b1, 1'b0, 32'h0000_0010, 32'h0,          F3_B,   32'hFFFF_FFEF);
    add_vec(1'b1, 1'b0, 32'h0000_0011, 32'h0,          F3_B,   32'h0000_0055);
    add_vec(1'b1, 1'b0, 32'h0000_0004, 32'h0,          F3_W,   32'hBBBB_AA78);

    // Reset with loads requested on both instances: outputs must be forced low
    Reset = 1'b0;
    main_idle();
    m_read = 1'b1; m_addr = 32'h4;
    l2_drive(1'b1, 1'b0, 32'h4, 32'h0);
    expect_out(0, 1'b0, 1'b1, 32'h0, 1'b0);
    expect_out(0, 1'b1, 1'b1, 32'h0, 1'b0);
    step();
    Reset = 1'b1;
    main_idle();
    l2_drive(1'b0, 1'b0, 32'h0, 32'h0);

    for (int i = 0; i < vt.size(); i++) begin
      v = vt[i];
      apply(v, i + 1);
    end

    // Reset in mid-test wipes the array
    m_read = 1'b1; m_write = 1'b0; m_addr = 32'h4; m_f3 = F3_W;
    Reset = 1'b0;
    expect_out(50, 1'b0, 1'b1, 32'h0, 1'b0);
    step();
    Reset = 1'b1;
    v.rd = 1'b1; v.wr = 1'b0; v.wdata = 32'h0; v.f3 = F3_W; v.exp_data = 32'h0;
    v.addr = 32'h4;      apply(v, 51);
    v.addr = 32'h10;     apply(v, 52);
    v.addr = DEPTH - 2;  apply(v, 53);
    main_idle();

    // LATENCY=2: store dropped after one wait edge must not write
    l2_drive(1'b0, 1'b1, 32'hC, 32'h5555_5555);
    expect_out(100, 1'b1, 1'b1, 32'h0, 1'b1);
    step();
    l2_drive(1'b0, 1'b0, 32'hC, 32'h0);
    expect_out(101, 1'b1, 1'b1, 32'h0, 1'b0);
    step();
    // Load of the aborted location: two busy edges, then data (still zero)
    l2_drive(1'b1, 1'b0, 32'hC, 32'h0);
    expect_out(102, 1'b1, 1'b0, 32'h0, 1'b1); step();
    expect_out(103, 1'b1, 1'b0, 32'h0, 1'b1); step();
    expect_out(104, 1'b1, 1'b1, 32'h0, 1'b0); step();
    // Full store held until busywait falls
    l2_drive(1'b0, 1'b1, 32'h8, 32'hCAFE_F00D);
    expect_out(105, 1'b1, 1'b1, 32'h0, 1'b1); step();
    expect_out(106, 1'b1, 1'b1, 32'h0, 1'b1); step();
    expect_out(107, 1'b1, 1'b1, 32'h0, 1'b0); step();
    // Load it back: data valid only once busywait is low
    l2_drive(1'b1, 1'b0, 32'h8, 32'h0);
    expect_out(108, 1'b1, 1'b0, 32'h0, 1'b1); step();
    expect_out(109, 1'b1, 1'b0, 32'h0, 1'b1); step();
    expect_out(110, 1'b1, 1'b1, 32'hCAFE_F00D, 1'b0); step();
    l2_drive(1'b0, 1'b0, 32'h0, 32'h0);
    expect_out(111, 1'b1, 1'b1, 32'h0, 1'b0); step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
